// File: rtl/ctrl_pkg.sv
// Shared types for the control sequencer: opcodes, ALUOp codes, FSM states and the control bus.
// S_TRAP exists only when ILLEGAL_TRAP_EN is defined.
package ctrl_pkg;

   typedef enum logic [3:0] {
      OP_LI  = 4'b0000,
      OP_LD  = 4'b0001,
      OP_ST  = 4'b0010,
      OP_ADD = 4'b0011,
      OP_SUB = 4'b0100,
      OP_XOR = 4'b0101,
      OP_OR  = 4'b0110,
      OP_AND = 4'b0111,
      OP_JMP = 4'b1000,
      OP_BEQ = 4'b1001,
      OP_BLT = 4'b1010,
      OP_BGT = 4'b1011,
      OP_SHL = 4'b1100,
      OP_SHR = 4'b1101,
      OP_X14 = 4'b1110,
      OP_X15 = 4'b1111
   } opcode_t;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_XOR  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0010;
   localparam logic [3:0] ALU_SHL  = 4'b0011;
   localparam logic [3:0] ALU_SHR  = 4'b0100;
   localparam logic [3:0] ALU_ADD  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_NONE = 4'b0111;

   typedef enum logic [1:0] {
      S_RUN,
      S_MEM,
      S_FLUSH
`ifdef ILLEGAL_TRAP_EN
      , S_TRAP
`endif
   } state_t;

   typedef struct packed {
      logic       branch;
      logic       mem_to_reg;
      logic       mem_write;
      logic       reg_write;
      logic       put;
      logic       imm_to_reg;
      logic [3:0] alu_op;
   } ctrl_bus_t;

   localparam ctrl_bus_t CTRL_IDLE = '{alu_op: ALU_NONE, default: '0};

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational decode of the run/put instruction encoding into a control bus.
// Opcodes 1110/1111 (and any unlisted code) are flagged on illegal_o with an idle bus.
module ctrl_decode_comb
   import ctrl_pkg::*;
#(
   parameter int unsigned OPC_W = 4
)(
   input  logic [OPC_W:0] instr_i,
   output ctrl_bus_t      ctrl_o,
   output logic           illegal_o
);

   opcode_t opc;

   always_comb begin
      opc       = opcode_t'(instr_i[OPC_W:1]);
      ctrl_o    = CTRL_IDLE;
      illegal_o = 1'b0;
      if (instr_i[0]) begin
         ctrl_o.put = 1'b1;
      end else begin
         case (opc)
            OP_LI:  begin ctrl_o.imm_to_reg = 1'b1; ctrl_o.reg_write = 1'b1; end
            OP_LD:  begin ctrl_o.mem_to_reg = 1'b1; ctrl_o.reg_write = 1'b1; end
            OP_ST:  ctrl_o.mem_write = 1'b1;
            OP_ADD: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_ADD; end
            OP_SUB: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SUB; end
            OP_XOR: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_XOR; end
            OP_OR:  begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_OR;  end
            OP_AND: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_AND; end
            OP_SHL: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SHL; end
            OP_SHR: begin ctrl_o.reg_write = 1'b1; ctrl_o.alu_op = ALU_SHR; end
            OP_JMP, OP_BEQ, OP_BLT, OP_BGT: ctrl_o.branch = 1'b1;
            default: illegal_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered control sequencer: valid/ready intake, multi-cycle memory ops, post-branch squash, retire counter.
// Define ILLEGAL_TRAP_EN to trap on opcodes 1110/1111 (adds illegal_op port and S_TRAP).
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int unsigned IW           = 9,
   parameter int unsigned OPC_W        = 4,
   parameter int unsigned ALUOP_W      = 4,
   parameter int unsigned MEM_LAT      = 2,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
)(
   input  logic               Clk,
   input  logic               Reset,
   input  logic [IW-1:0]      instruction,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic               out_valid,
   output logic               branchFlag,
   output logic               memToRegFlag,
   output logic               memWriteFlag,
   output logic               regWriteFlag,
   output logic               putFlag,
   output logic               immtoRegFlag,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               mem_last,
   output logic [CNT_W-1:0]   retired
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic               illegal_op
`endif
);

   localparam int unsigned MW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned FW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

   state_t           state_q, state_d;
   logic [MW-1:0]    mem_cnt_q, mem_cnt_d;
   logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
   ctrl_bus_t        bus_q, bus_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   ctrl_bus_t        dec_bus;
   logic             dec_ill;
`ifdef ILLEGAL_TRAP_EN
   logic             ill_q, ill_d;
`endif

   ctrl_decode_comb #(.OPC_W(OPC_W)) u_decode (
      .instr_i   (instruction[OPC_W:0]),
      .ctrl_o    (dec_bus),
      .illegal_o (dec_ill)
   );

   if (IW > OPC_W + 1) begin : g_spare
      logic unused_hi;
      assign unused_hi = ^instruction[IW-1:OPC_W+1];
   end

   always_comb begin
      state_d     = state_q;
      mem_cnt_d   = mem_cnt_q;
      flush_cnt_d = flush_cnt_q;
      bus_d       = CTRL_IDLE;
      valid_d     = 1'b0;
      last_d      = 1'b0;
      ret_d       = ret_q;
`ifdef ILLEGAL_TRAP_EN
      ill_d       = 1'b0;
`endif
      case (state_q)
         S_RUN: begin
            if (instr_valid) begin
               if (dec_ill) begin
`ifdef ILLEGAL_TRAP_EN
                  ill_d   = 1'b1;
                  state_d = S_TRAP;
`else
                  valid_d = 1'b1;
                  ret_d   = ret_q + 1'b1;
`endif
               end else begin
                  bus_d   = dec_bus;
                  valid_d = 1'b1;
                  if (dec_bus.mem_to_reg || dec_bus.mem_write) begin
                     if (MEM_LAT > 1) begin
                        // Load write-back is withheld until the final memory cycle.
                        bus_d.reg_write = 1'b0;
                        state_d         = S_MEM;
                        mem_cnt_d       = MW'(MEM_LAT - 1);
                     end else begin
                        last_d = 1'b1;
                        ret_d  = ret_q + 1'b1;
                     end
                  end else begin
                     ret_d = ret_q + 1'b1;
                     if (dec_bus.branch && (FLUSH_CYCLES > 0)) begin
                        state_d     = S_FLUSH;
                        flush_cnt_d = FW'(FLUSH_CYCLES);
                     end
                  end
               end
            end
         end
         S_MEM: begin
            if (mem_cnt_q != '0) begin
               bus_d     = bus_q;
               valid_d   = 1'b1;
               mem_cnt_d = mem_cnt_q - 1'b1;
               if (mem_cnt_q == MW'(1)) begin
                  last_d          = 1'b1;
                  bus_d.reg_write = bus_q.mem_to_reg;
                  ret_d           = ret_q + 1'b1;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_FLUSH: begin
            if (instr_valid) begin
               flush_cnt_d = flush_cnt_q - 1'b1;
               if (flush_cnt_q <= FW'(1)) state_d = S_RUN;
            end
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: state_d = S_TRAP;
`endif
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_RUN;
         mem_cnt_q   <= '0;
         flush_cnt_q <= '0;
         bus_q       <= CTRL_IDLE;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         ret_q       <= '0;
`ifdef ILLEGAL_TRAP_EN
         ill_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mem_cnt_q   <= mem_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         bus_q       <= bus_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         ret_q       <= ret_d;
`ifdef ILLEGAL_TRAP_EN
         ill_q       <= ill_d;
`endif
      end
   end

   assign instr_ready  = !Reset && ((state_q == S_RUN) || (state_q == S_FLUSH));
   assign out_valid    = valid_q;
   assign branchFlag   = bus_q.branch;
   assign memToRegFlag = bus_q.mem_to_reg;
   assign memWriteFlag = bus_q.mem_write;
   assign regWriteFlag = bus_q.reg_write;
   assign putFlag      = bus_q.put;
   assign immtoRegFlag = bus_q.imm_to_reg;
   assign ALUOp        = ALUOP_W'(bus_q.alu_op);
   assign mem_last     = last_q;
   assign retired      = ret_q;
`ifdef ILLEGAL_TRAP_EN
   assign illegal_op   = ill_q;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer: directed scenarios then randomized traffic vs. a reference model.
module tb_ctrl_sequencer;

   localparam int unsigned IW           = 9;
   localparam int unsigned MEM_LAT      = 2;
   localparam int unsigned FLUSH_CYCLES = 1;
   localparam int unsigned CNT_W        = 4;

   logic             Clk = 1'b0;
   logic             Reset = 1'b1;
   logic [IW-1:0]    instruction = '0;
   logic             instr_valid = 1'b0;
   logic             instr_ready, out_valid;
   logic             branchFlag, memToRegFlag, memWriteFlag, regWriteFlag, putFlag, immtoRegFlag;
   logic [3:0]       ALUOp;
   logic             mem_last;
   logic [CNT_W-1:0] retired;
`ifdef ILLEGAL_TRAP_EN
   logic             illegal_op;
`endif

   ctrl_sequencer #(
      .IW(IW), .MEM_LAT(MEM_LAT), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .Clk(Clk), .Reset(Reset), .instruction(instruction), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .out_valid(out_valid), .branchFlag(branchFlag),
      .memToRegFlag(memToRegFlag), .memWriteFlag(memWriteFlag), .regWriteFlag(regWriteFlag),
      .putFlag(putFlag), .immtoRegFlag(immtoRegFlag), .ALUOp(ALUOp), .mem_last(mem_last),
      .retired(retired)
`ifdef ILLEGAL_TRAP_EN
      , .illegal_op(illegal_op)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic br, m2r, mw, rw, put, imm;
      logic [3:0] alu;
      logic last, rdy;
      logic [CNT_W-1:0] ret;
   } beat_t;

   beat_t            exp_q[$];
   int               compared = 0;
   int               mismatched = 0;
   logic [CNT_W-1:0] model_ret = '0;
   logic [CNT_W-1:0] last_ret = '0;
   int               flush_left = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [IW-1:0] mk(input logic itype, input logic [3:0] opc);
      logic [3:0] junk;
      junk = 4'($urandom);
      return {junk, opc, itype};
   endfunction

   // Reference model: what each accepted instruction should show on the output, one entry per valid cycle.
   function automatic void model_accept(input logic [IW-1:0] ins);
      beat_t b;
      logic [3:0] opc;
      if (flush_left > 0) begin
         flush_left--;
         return;
      end
      b = '0;
      b.alu = 4'b0111;
      b.rdy = 1'b1;
      opc = ins[4:1];
      if (ins[0]) begin
         b.put = 1'b1;
         model_ret = model_ret + 1'b1;
         b.ret = model_ret;
         exp_q.push_back(b);
         return;
      end
      if (opc == 4'd1 || opc == 4'd2) begin
         for (int k = 1; k <= int'(MEM_LAT); k++) begin
            b.m2r  = (opc == 4'd1);
            b.mw   = (opc == 4'd2);
            b.rdy  = (MEM_LAT == 1);
            b.last = (k == int'(MEM_LAT));
            b.rw   = b.m2r && b.last;
            if (b.last) model_ret = model_ret + 1'b1;
            b.ret  = model_ret;
            exp_q.push_back(b);
         end
         return;
      end
      model_ret = model_ret + 1'b1;
      b.ret = model_ret;
      case (opc)
         4'd0:  begin b.imm = 1'b1; b.rw = 1'b1; end
         4'd3:  begin b.rw = 1'b1; b.alu = 4'b0101; end
         4'd4:  begin b.rw = 1'b1; b.alu = 4'b0110; end
         4'd5:  begin b.rw = 1'b1; b.alu = 4'b0001; end
         4'd6:  begin b.rw = 1'b1; b.alu = 4'b0010; end
         4'd7:  begin b.rw = 1'b1; b.alu = 4'b0000; end
         4'd12: begin b.rw = 1'b1; b.alu = 4'b0011; end
         4'd13: begin b.rw = 1'b1; b.alu = 4'b0100; end
         4'd8, 4'd9, 4'd10, 4'd11: begin b.br = 1'b1; flush_left = int'(FLUSH_CYCLES); end
         default: ;
      endcase
      exp_q.push_back(b);
   endfunction

   beat_t mon_act, mon_exp;

   always @(negedge Clk) begin
      if (!Reset) begin
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               mon_exp = exp_q.pop_front();
               mon_act = {branchFlag, memToRegFlag, memWriteFlag, regWriteFlag, putFlag, immtoRegFlag,
                          ALUOp, mem_last, instr_ready, retired};
               check("beat", mon_act, mon_exp);
               last_ret = mon_exp.ret;
            end
         end else begin
            check("idle_flags", {branchFlag, memToRegFlag, memWriteFlag, regWriteFlag, putFlag,
                                 immtoRegFlag, mem_last, retired}, {7'b0, last_ret});
         end
      end
   end

   task automatic issue(input logic [IW-1:0] ins, input int gap);
      logic rdy;
      int waited;
      waited = 0;
      rdy = 1'b0;
      if (gap > 0) begin
         instr_valid = 1'b0;
         repeat (gap) @(posedge Clk);
         #1;
      end
      instruction = ins;
      instr_valid = 1'b1;
      forever begin
         @(negedge Clk);
         rdy = instr_ready;
         @(posedge Clk);
         #1;
         if (rdy) break;
         waited++;
         if (waited > 50) begin
            check("ready_timeout", 64'd0, 64'd1);
            break;
         end
      end
      if (rdy) model_accept(ins);
   endtask

   task automatic idle(input int n);
      instr_valid = 1'b0;
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {out_valid, branchFlag, memToRegFlag, memWriteFlag, regWriteFlag, putFlag,
                   immtoRegFlag, mem_last, ALUOp, retired}, {8'b0, 4'b0111, {CNT_W{1'b0}}});
   endtask

   task automatic apply_reset();
      instr_valid = 1'b0;
      Reset = 1'b1;
      exp_q.delete();
      model_ret = '0;
      last_ret = '0;
      flush_left = 0;
      @(posedge Clk);
      @(negedge Clk);
      check_reset_outputs("reset_outputs");
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      @(negedge Clk);
      check("ready_after_reset", {63'b0, instr_ready}, 64'd1);
      @(posedge Clk);
      #1;
   endtask

   int drain_wait;

   initial begin
      repeat (2) @(posedge Clk);
      #1;
      apply_reset();

      // 1: single ALU op
      issue(mk(1'b0, 4'b0011), 0);
      idle(2);
      // 2: load through the memory sequence
      issue(mk(1'b0, 4'b0001), 1);
      idle(3);
      // 3: branch then two followers, first one squashed
      issue(mk(1'b0, 4'b1001), 1);
      issue(mk(1'b0, 4'b0011), 0);
      issue(mk(1'b0, 4'b0101), 0);
      idle(2);
      // 4: reset while the load is still in its memory cycles
      issue(mk(1'b0, 4'b0001), 1);
      apply_reset();
      // 5: counter wrap with CNT_W=4
      for (int i = 0; i < 17; i++) issue(mk(1'b0, 4'(3 + $urandom_range(0, 4))), 0);
      idle(2);
      @(negedge Clk);
      check("retired_wrap", {{(64-CNT_W){1'b0}}, retired}, 64'd1);
      @(posedge Clk);
      #1;
`ifndef ILLEGAL_TRAP_EN
      issue(mk(1'b0, 4'b1111), 1);
      issue(mk(1'b0, 4'b1110), 0);
      idle(2);
`endif
      // 6: put back-to-back with xor
      issue(mk(1'b1, 4'($urandom)), 1);
      issue(mk(1'b0, 4'b0101), 0);
      idle(2);

      for (int i = 0; i < 300; i++) begin
         logic [3:0] opc;
         logic       it;
         int         gap;
`ifdef ILLEGAL_TRAP_EN
         opc = 4'($urandom_range(0, 13));
`else
         opc = 4'($urandom_range(0, 15));
`endif
         it  = ($urandom_range(0, 7) == 0);
         gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         issue(mk(it, opc), gap);
      end
      idle(1);

      drain_wait = 0;
      while (exp_q.size() != 0 && drain_wait < 20) begin
         @(posedge Clk);
         drain_wait++;
      end
      #1;
      check("drain", 64'(exp_q.size()), 64'd0);

`ifdef ILLEGAL_TRAP_EN
      apply_reset();
      instruction = mk(1'b0, 4'b1111);
      instr_valid = 1'b1;
      @(posedge Clk);
      #1;
      instr_valid = 1'b0;
      @(negedge Clk);
      check("illegal_pulse", {62'b0, illegal_op, out_valid}, 64'b10);
      @(negedge Clk);
      check("illegal_one_cycle", {62'b0, illegal_op, instr_ready}, 64'b00);
      instr_valid = 1'b1;
      repeat (3) @(negedge Clk);
      check("trap_sticky", {62'b0, instr_ready, out_valid}, 64'b00);
      instr_valid = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
